// File: rtl/mdu_sequencer_if.sv
// E-stage to MDU handshake bundle: issue/operands in, occupancy, stall and HI/LO out.
interface mdu_sequencer_if;
  logic        Start;
  logic [2:0]  MdOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        MdUse;
  logic        Busy;
  logic        StallReq;
  logic [31:0] Hi;
  logic [31:0] Lo;

  modport master (
    output Start,
    output MdOp,
    output A,
    output B,
    output MdUse,
    input  Busy,
    input  StallReq,
    input  Hi,
    input  Lo
  );

  modport slave (
    input  Start,
    input  MdOp,
    input  A,
    input  B,
    input  MdUse,
    output Busy,
    output StallReq,
    output Hi,
    output Lo
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Multiply/divide unit for the E stage: computes at issue, models occupancy with a
// countdown, and commits the latched result to HI/LO when the countdown expires.
module mdu_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic            clk,
  input logic            reset,
  mdu_sequencer_if.slave bus
);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [1:0] {StIdle, StMult, StDiv} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              busy_q;
  logic              div_zero_q;
  logic [31:0]       hi_q, lo_q;
  logic [31:0]       res_hi_q, res_lo_q;

  logic              is_mul, is_div, is_mthi, is_mtlo, is_signed;
  logic [63:0]       mul_a, mul_b, product;
  logic [31:0]       a_mag, b_mag, d_mag, q_mag, r_mag, quot, rem;

  always_comb begin
    is_mul    = bus.Start & ((bus.MdOp == OpMult) | (bus.MdOp == OpMultu));
    is_div    = bus.Start & ((bus.MdOp == OpDiv) | (bus.MdOp == OpDivu));
    is_mthi   = bus.Start & (bus.MdOp == OpMthi);
    is_mtlo   = bus.Start & (bus.MdOp == OpMtlo);
    is_signed = (bus.MdOp == OpMult) | (bus.MdOp == OpDiv);
  end

  // Sign/zero-extend to 64 bits so one multiplier serves both mult and multu.
  always_comb begin
    mul_a   = is_signed ? {{32{bus.A[31]}}, bus.A} : {32'h0, bus.A};
    mul_b   = is_signed ? {{32{bus.B[31]}}, bus.B} : {32'h0, bus.B};
    product = mul_a * mul_b;
  end

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    a_mag = (is_signed && bus.A[31]) ? -bus.A : bus.A;
    b_mag = (is_signed && bus.B[31]) ? -bus.B : bus.B;
    d_mag = (b_mag == 32'h0) ? 32'h1 : b_mag;
    q_mag = a_mag / d_mag;
    r_mag = a_mag % d_mag;
    quot  = (is_signed && (bus.A[31] ^ bus.B[31])) ? -q_mag : q_mag;
    rem   = (is_signed && bus.A[31]) ? -r_mag : r_mag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (is_mul) begin
            res_hi_q   <= product[63:32];
            res_lo_q   <= product[31:0];
            div_zero_q <= 1'b0;
            cnt_q      <= CntW'(MULT_CYCLES);
            busy_q     <= 1'b1;
            state_q    <= StMult;
          end else if (is_div) begin
            res_hi_q   <= rem;
            res_lo_q   <= quot;
            div_zero_q <= (bus.B == 32'h0);
            cnt_q      <= CntW'(DIV_CYCLES);
            busy_q     <= 1'b1;
            state_q    <= StDiv;
          end else if (is_mthi) begin
            hi_q <= bus.A;
          end else if (is_mtlo) begin
            lo_q <= bus.A;
          end
        end
        StMult, StDiv: begin
          if (cnt_q == CntW'(1)) begin
            // A zero divisor still occupies the unit but leaves HI/LO untouched.
            if (!div_zero_q) begin
              hi_q <= res_hi_q;
              lo_q <= res_lo_q;
            end
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    bus.Busy     = busy_q;
    bus.Hi       = hi_q;
    bus.Lo       = lo_q;
    bus.StallReq = bus.MdUse & (busy_q | is_mul | is_div);
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboarded bench for mdu_sequencer: directed corners plus randomized ops against
// a plain-arithmetic model of HI/LO; a monitor checks each completion as Busy falls.
module tb_mdu_sequencer;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mdu_sequencer_if bus ();

  mdu_sequencer #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_hi     = '0;
  logic [31:0] m_lo     = '0;

  function automatic void check32(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void checkint(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Architectural model: what HI/LO must hold once the op has completed.
  function automatic void model_op(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    longint          sa, sbv, q, r;
    longint unsigned ua, ub;
    logic [63:0]     p;
    exp_t            e;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    case (op)
      3'd1: begin p = sa * sbv; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin p = ua * ub;  m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd3: if (b != 0) begin
        q = sa / sbv; r = sa % sbv;
        p = q; m_lo = p[31:0];
        p = r; m_hi = p[31:0];
      end
      3'd4: if (b != 0) begin
        p = ua / ub; m_lo = p[31:0];
        p = ua % ub; m_hi = p[31:0];
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
    if (op >= 3'd1 && op <= 3'd4) begin
      e.hi = m_hi;
      e.lo = m_lo;
      e.cycles = (op <= 3'd2) ? int'(MC) : int'(DC);
      sb.push_back(e);
    end
  endfunction

  // Completion monitor: measures each busy window and checks HI/LO when it closes.
  int   bcnt      = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      bcnt      = 0;
      prev_busy = 1'b0;
    end else begin
      if (bus.Busy) begin
        bcnt++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_completion: got a completion, expected none");
        end else begin
          e = sb.pop_front();
          checkint("busy_cycles", bcnt, e.cycles);
          check32("done_hi", bus.Hi, e.hi);
          check32("done_lo", bus.Lo, e.lo);
        end
        bcnt = 0;
      end
      prev_busy = bus.Busy;
    end
  end

  // Called 1ns after a rising edge with the DUT idle; returns 1ns after the issue edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic use_md);
    bus.Start = 1'b1;
    bus.MdOp  = op;
    bus.A     = a;
    bus.B     = b;
    bus.MdUse = use_md;
    @(negedge clk);
    check32("stall_issue", 32'(bus.StallReq), 32'(use_md && op >= 3'd1 && op <= 3'd4));
    model_op(op, a, b);
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    bus.MdOp  = 3'd0;
    bus.A     = $urandom();
    bus.B     = $urandom();
    if (op == 3'd5 || op == 3'd6) begin
      @(negedge clk);
      check32("mt_busy", 32'(bus.Busy), 32'd0);
      check32("mt_hi", bus.Hi, m_hi);
      check32("mt_lo", bus.Lo, m_lo);
    end
  endtask

  // Waits for Busy low; if stall_cycles >= 0, StallReq must be high for exactly that many
  // samples. Ends 1ns after a rising edge.
  task automatic wait_idle(input int stall_cycles);
    int n = 0;
    do begin
      @(negedge clk);
      if (stall_cycles >= 0)
        check32("stall_busy", 32'(bus.StallReq), 32'(n < stall_cycles));
      n++;
    end while (bus.Busy && n < 100);
    if (bus.Busy) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout: got Busy=1 after %0d cycles, expected 0", n);
    end
    check32("arch_hi", bus.Hi, m_hi);
    check32("arch_lo", bus.Lo, m_lo);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    bus.Start = 1'b0;
    bus.MdOp  = 3'd0;
    bus.A     = '0;
    bus.B     = '0;
    bus.MdUse = 1'b1;

    #12;
    check32("rst_busy", 32'(bus.Busy), 32'd0);
    check32("rst_hi", bus.Hi, 32'h0);
    check32("rst_lo", bus.Lo, 32'h0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check32("idle_stall", 32'(bus.StallReq), 32'd0);
    @(posedge clk);
    #1;

    // Directed corners; the first mult also checks the stall window.
    issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_idle(MC);
    bus.MdUse = 1'b0;
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle(-1);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(-1);
    issue(3'd4, 32'd7, 32'd2, 1'b0);
    wait_idle(-1);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(-1);
    issue(3'd3, 32'h1234, 32'h0, 1'b0);
    wait_idle(-1);
    issue(3'd5, 32'h1234_5678, 32'h0, 1'b0);
    wait_idle(-1);

    // Issues while busy must be ignored.
    issue(3'd1, 32'h0000_0003, 32'hFFFF_FFFB, 1'b0);
    bus.Start = 1'b1;
    bus.MdOp  = 3'd6;
    bus.A     = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.MdOp  = 3'd3;
    bus.B     = 32'h0;
    @(posedge clk);
    #1;
    bus.MdOp  = 3'd5;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    bus.MdOp  = 3'd0;
    wait_idle(-1);

    // Randomized ops with corner-weighted operands.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        default: a = $urandom();
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2, 3:    b = 32'($urandom_range(1, 20));
        default: b = $urandom();
      endcase
      bus.MdUse = 1'($urandom_range(0, 1));
      issue(op, a, b, bus.MdUse);
      wait_idle(-1);
    end

    // Reset three cycles into a divide aborts it and clears HI/LO.
    issue(3'd4, 32'd100, 32'd7, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    #1;
    check32("abort_busy", 32'(bus.Busy), 32'd0);
    check32("abort_hi", bus.Hi, 32'h0);
    check32("abort_lo", bus.Lo, 32'h0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    issue(3'd1, 32'd6, 32'd7, 1'b0);
    wait_idle(-1);

    checkint("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multiply/divide unit with built-in sequencing for the pipelined MIPS core. Sits in the E stage beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo issues from the E stage.
- Models multi-cycle occupancy with a countdown state machine and owns the architectural HI/LO registers.
- Produces the busy/stall request that the hazard unit uses to hold D-stage instructions that need the MDU.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- Start  input  1  E-stage instruction valid for MDU this cycle.
- MdOp  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 reserved, treated as none.
- A  input  32  rs operand (dividend / multiplicand / mthi-mtlo source).
- B  input  32  rt operand (divisor / multiplier).
- MdUse  input  1  D-stage instruction requires MDU (any MdOp, or mfhi/mflo).
- Busy  output  1  MDU occupied by an in-flight mult/div.
- StallReq  output  1  combinational: MdUse & (Busy | (Start & MdOp in 1..4)).
- Hi  output  32  HI register.
- Lo  output  32  LO register.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, counter=0, Busy=0, Hi=0, Lo=0, internal result latches=0.
  - Reset asserted mid-operation aborts it; HI/LO are not written.
- States: IDLE, MULT, DIV. Busy = (state != IDLE).
- IDLE transitions:
  - Start & MdOp in {1,2}: compute the 64-bit product into the result latch; counter <= MULT_CYCLES; state <= MULT.
  - Start & MdOp in {3,4}: compute quotient/remainder into the result latch; counter <= DIV_CYCLES; state <= DIV.
  - Start & MdOp==5: Hi <= A at this edge. Busy stays 0. Lo unchanged.
  - Start & MdOp==6: Lo <= A at this edge. Busy stays 0. Hi unchanged.
  - Otherwise: hold.
- MULT/DIV states:
  - Counter decrements each edge.
  - At the edge where counter==1: {Hi,Lo} <= result latch; state <= IDLE.
- Timing: Start sampled at edge k gives Busy high for exactly N cycles after edge k. New Hi/Lo are visible the same cycle Busy falls.
- Start while Busy (any MdOp): ignored. The stall protocol makes this unreachable, and the bench checks that it is ignored.
- Arithmetic:
  - mult: signed 32x32 -> 64; Hi = product[63:32], Lo = product[31:0].
  - multu: unsigned 32x32 -> 64; same split as mult.
  - div: Lo = quotient truncated toward zero; Hi = remainder with the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF: Lo = 0x80000000, Hi = 0.
  - divu: unsigned quotient to Lo, remainder to Hi.
  - Divide by zero (B==0): the sequence still runs DIV_CYCLES with Busy high. HI/LO are not written at completion.
- Operands are captured at the issue edge. Later changes to A/B do not affect the in-flight result.
- StallReq:
  - Asserted in the issue cycle (Start with mult/div) so the next MDU user in D is held.
  - Stays asserted while Busy.
  - Deasserts in the cycle Busy falls. In that cycle mfhi/mflo read the new values.
- Hi/Lo are only written by completion, mthi or mtlo. Plain read paths have no side effects.

Test Plan:
- Reset release, then mult with A=0xFFFFFFFF, B=2 -> Busy high 5 cycles; then Hi=0xFFFFFFFF, Lo=0xFFFFFFFE.
- multu with A=0xFFFFFFFF, B=2 -> Hi=0x00000001, Lo=0xFFFFFFFE after 5 busy cycles.
- div with A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles; Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. divu with A=7, B=2 -> Lo=3, Hi=1.
- Overflow and divide-by-zero:
  - div with A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
  - Then div with B=0 -> Busy 10 cycles; Hi/Lo unchanged.
- Hazard and ignore behaviour:
  - mthi A=0x12345678 -> Hi updates next edge with Busy=0.
  - Issue mult with MdUse=1 -> StallReq=1 in the issue cycle and all 5 busy cycles, then 0.
  - Start with mtlo during Busy -> ignored; Lo gets the mult result only.
- Reset mid-operation: drive reset low 3 cycles into a div -> immediately Busy=0, Hi=Lo=0, state IDLE. After release, a new mult completes normally.
